// File: rtl/btb_pkg.sv
// btb_pkg: shared opcodes, BTB entry layout and 2-bit saturating counter helpers
package btb_pkg;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    typedef logic [1:0] ctr2_t;
    localparam ctr2_t CTR_WNT = 2'b01;
    // Tag is held at full width; bits above the real tag are always written as zero.
    typedef struct packed {
        logic        valid;
        logic        is_jump;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;
    function automatic ctr2_t sat_inc(input ctr2_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction
    function automatic ctr2_t sat_dec(input ctr2_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction
endpackage

// File: rtl/branch_pht.sv
// branch_pht: 2-bit saturating pattern history table with optional gshare history
// Ports: clk, rst (sync active-high); i_look_pc fetch PC, o_look_taken counter MSB for it;
//        i_upd_pc/i_train/i_br_en train one counter, o_upd_taken counter MSB at i_upd_pc.
// Macro BTB_GSHARE_EN: adds a GHR_W-bit global history XORed into both indices.
module branch_pht
    import btb_pkg::*;
#(
    parameter int PHT_IDX_W = 6,
    parameter int GHR_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_look_pc,
    input  logic [31:0] i_upd_pc,
    input  logic        i_train,
    input  logic        i_br_en,
    output logic        o_look_taken,
    output logic        o_upd_taken
);
    localparam int N = 1 << PHT_IDX_W;
    ctr2_t                r_pht [N];
    logic [GHR_W-1:0]     w_ghr;
    logic [PHT_IDX_W-1:0] w_lidx;
    logic [PHT_IDX_W-1:0] w_uidx;
`ifdef BTB_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;
    assign w_ghr = r_ghr;
    always_ff @(posedge clk) begin
        if (rst) r_ghr <= '0;
        else if (i_train) r_ghr <= GHR_W'({r_ghr, i_br_en});
    end
`else
    assign w_ghr = '0;
`endif
    // Training indexes with the history seen before this branch shifts in.
    assign w_lidx       = PHT_IDX_W'(i_look_pc >> 2) ^ PHT_IDX_W'(w_ghr);
    assign w_uidx       = PHT_IDX_W'(i_upd_pc >> 2) ^ PHT_IDX_W'(w_ghr);
    assign o_look_taken = r_pht[w_lidx][1];
    assign o_upd_taken  = r_pht[w_uidx][1];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_pht[i] <= CTR_WNT;
        end else if (i_train) begin
            r_pht[w_uidx] <= i_br_en ? sat_inc(r_pht[w_uidx]) : sat_dec(r_pht[w_uidx]);
        end
    end
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: IF-stage direct-mapped BTB + 2-bit PHT predictor trained from ID/EX
// Ports: clk, rst (sync active-high); if_pc lookup -> prediction, tag_comp, predicted_pc, btb_target;
//        stall blocks all training; upd_* describe the resolved ID/EX instruction;
//        mispredict_cnt saturating count of conditional-branch mispredicts.
// Macro BTB_GSHARE_EN: gshare PHT indexing (handled inside branch_pht).
module branch_target_predictor
    import btb_pkg::*;
#(
    parameter int BTB_IDX_W = 4,
    parameter int PHT_IDX_W = 6,
    parameter int GHR_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        stall,
    output logic        prediction,
    output logic        tag_comp,
    output logic [31:0] predicted_pc,
    output logic [31:0] btb_target,
    input  logic        upd_valid,
    input  logic        upd_invalidate,
    input  logic [6:0]  upd_opcode,
    input  logic [31:0] upd_pc,
    input  logic        upd_br_en,
    input  logic [31:0] upd_target,
    output logic [15:0] mispredict_cnt
);
    localparam int N = 1 << BTB_IDX_W;
    btb_entry_t           r_btb [N];
    logic [15:0]          r_mis;
    logic [BTB_IDX_W-1:0] w_idx;
    logic [BTB_IDX_W-1:0] w_uidx;
    logic [31:0]          w_tag;
    logic [31:0]          w_utag;
    logic                 w_look_taken;
    logic                 w_upd_taken;
    logic                 w_tr;
    logic                 w_br;
    logic                 w_jmp;
    logic                 w_uhit;
    logic                 w_upd_pred;
    assign w_idx  = BTB_IDX_W'(if_pc >> 2);
    assign w_uidx = BTB_IDX_W'(upd_pc >> 2);
    assign w_tag  = if_pc >> (BTB_IDX_W + 2);
    assign w_utag = upd_pc >> (BTB_IDX_W + 2);
    assign w_tr   = upd_valid && !upd_invalidate && !stall;
    assign w_br   = upd_opcode == OP_BR;
    assign w_jmp  = upd_opcode == OP_JAL || upd_opcode == OP_JALR;
    branch_pht #(.PHT_IDX_W(PHT_IDX_W), .GHR_W(GHR_W)) u_pht (
        .clk          (clk),
        .rst          (rst),
        .i_look_pc    (if_pc),
        .i_upd_pc     (upd_pc),
        .i_train      (w_tr && w_br),
        .i_br_en      (upd_br_en),
        .o_look_taken (w_look_taken),
        .o_upd_taken  (w_upd_taken)
    );
    assign tag_comp       = r_btb[w_idx].valid && r_btb[w_idx].tag == w_tag;
    assign prediction     = tag_comp && (r_btb[w_idx].is_jump || w_look_taken);
    assign predicted_pc   = prediction ? r_btb[w_idx].target : if_pc + 32'd4;
    assign btb_target     = tag_comp ? r_btb[w_idx].target : '0;
    assign mispredict_cnt = r_mis;
    // Re-run the fetch-time lookup rule on upd_pc against current tables to judge the prediction.
    assign w_uhit     = r_btb[w_uidx].valid && r_btb[w_uidx].tag == w_utag;
    assign w_upd_pred = w_uhit && (r_btb[w_uidx].is_jump || w_upd_taken);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_btb[i] <= '0;
            r_mis <= '0;
        end else if (w_tr) begin
            if ((w_br && upd_br_en) || w_jmp)
                r_btb[w_uidx] <= '{valid: 1'b1, is_jump: w_jmp, tag: w_utag, target: upd_target};
            if (w_br && upd_br_en != w_upd_pred && r_mis != 16'hFFFF)
                r_mis <= r_mis + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed + random stimulus checked against a table-level model
module tb_branch_target_predictor;
    import btb_pkg::*;
    localparam int NB = 16;
    localparam int NP = 64;
    localparam int GW = 6;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] if_pc = 0;
    logic        stall = 0;
    logic        prediction, tag_comp;
    logic [31:0] predicted_pc, btb_target;
    logic        upd_valid = 0, upd_invalidate = 0, upd_br_en = 0;
    logic [6:0]  upd_opcode = 0;
    logic [31:0] upd_pc = 0, upd_target = 0;
    logic [15:0] mispredict_cnt;
    int vectors = 0;
    int miscompares = 0;

    branch_target_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .stall(stall),
        .prediction(prediction), .tag_comp(tag_comp), .predicted_pc(predicted_pc),
        .btb_target(btb_target), .upd_valid(upd_valid), .upd_invalidate(upd_invalidate),
        .upd_opcode(upd_opcode), .upd_pc(upd_pc), .upd_br_en(upd_br_en),
        .upd_target(upd_target), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by PC arithmetic.
    bit          m_valid [NB];
    bit          m_jmp   [NB];
    longint      m_tag   [NB];
    logic [31:0] m_tgt   [NB];
    int          m_pht   [NP];
    int          m_ghr;
    int          m_mis;

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc / 4) % NB);
    endfunction
    function automatic int pidx(input logic [31:0] pc);
`ifdef BTB_GSHARE_EN
        return int'(((pc / 4) % NP)) ^ m_ghr;
`else
        return int'((pc / 4) % NP);
`endif
    endfunction
    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[bidx(pc)] && m_tag[bidx(pc)] == longint'(pc / (4 * NB));
    endfunction
    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_jmp[bidx(pc)] || m_pht[pidx(pc)] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) begin
            m_valid[i] = 0; m_jmp[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < NP; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_mis = 0;
    endtask

    task automatic m_write(input logic [31:0] pc, input bit jmp, input logic [31:0] tgt);
        m_valid[bidx(pc)] = 1;
        m_jmp[bidx(pc)]   = jmp;
        m_tag[bidx(pc)]   = longint'(pc / (4 * NB));
        m_tgt[bidx(pc)]   = tgt;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive, compare outputs before the edge, then advance the model.
    task automatic cyc(input bit r, input logic [31:0] pc, input bit st, input bit v, input bit inv,
                       input logic [6:0] op, input logic [31:0] upc, input bit br, input logic [31:0] tgt);
        int p;
        bit pr;
        @(negedge clk);
        rst = r; if_pc = pc; stall = st; upd_valid = v; upd_invalidate = inv;
        upd_opcode = op; upd_pc = upc; upd_br_en = br; upd_target = tgt;
        #1;
        check("tag_comp", 32'(tag_comp), 32'(m_hit(pc)));
        check("prediction", 32'(prediction), 32'(m_pred(pc)));
        check("predicted_pc", predicted_pc, m_pred(pc) ? m_tgt[bidx(pc)] : pc + 32'd4);
        check("btb_target", btb_target, m_hit(pc) ? m_tgt[bidx(pc)] : 32'd0);
        check("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
        @(posedge clk);
        if (r) m_reset();
        else if (v && !inv && !st) begin
            if (op == OP_BR) begin
                pr = m_pred(upc);
                p  = pidx(upc);
                if (br != pr && m_mis < 65535) m_mis++;
                m_pht[p] = br ? ((m_pht[p] < 3) ? m_pht[p] + 1 : 3) : ((m_pht[p] > 0) ? m_pht[p] - 1 : 0);
                if (br) m_write(upc, 0, tgt);
                m_ghr = ((m_ghr << 1) | int'(br)) % (1 << GW);
            end else if (op == OP_JAL || op == OP_JALR) begin
                m_write(upc, 1, tgt);
            end
        end
    endtask

    task automatic idle(input logic [31:0] pc);
        cyc(0, pc, 0, 0, 0, 7'h13, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] bpc, jpc, lpc;
        logic [6:0]  op;
        m_reset();
        repeat (2) @(posedge clk);
        // Reset state
        cyc(1, 32'h40, 0, 0, 0, 7'h13, 0, 0, 0);
        idle(32'h40);
        check("rst_predpc", predicted_pc, 32'h44);
        // Train taken twice, then not-taken twice
        cyc(0, 32'h40, 0, 1, 0, OP_BR, 32'h40, 1, 32'h80);
        cyc(0, 32'h40, 0, 1, 0, OP_BR, 32'h40, 1, 32'h80);
        idle(32'h40);
        check("taken_predpc", predicted_pc, 32'h80);
        cyc(0, 32'h40, 0, 1, 0, OP_BR, 32'h40, 0, 32'h80);
        cyc(0, 32'h40, 0, 1, 0, OP_BR, 32'h40, 0, 32'h80);
        idle(32'h40);
        check("nt_predpc", predicted_pc, 32'h44);
        // JAL held under stall, then released
        repeat (3) cyc(0, 32'h100, 1, 1, 0, OP_JAL, 32'h100, 0, 32'h200);
        cyc(0, 32'h100, 0, 1, 0, OP_JAL, 32'h100, 0, 32'h200);
        idle(32'h100);
        check("jal_predpc", predicted_pc, 32'h200);
        // Conflicting tag eviction and squashed train
        cyc(0, 32'h40, 0, 1, 0, OP_BR, 32'h40, 1, 32'h80);
        cyc(0, 32'h440, 0, 1, 0, OP_BR, 32'h440, 1, 32'h900);
        idle(32'h40);
        cyc(0, 32'h40, 0, 1, 1, OP_BR, 32'h40, 1, 32'h80);
        idle(32'h40);
        // Same-cycle lookup sees old contents; reset during a train
        cyc(0, 32'h3C, 0, 1, 0, OP_JALR, 32'h3C, 0, 32'h700);
        idle(32'h3C);
        cyc(1, 32'h3C, 0, 1, 0, OP_JAL, 32'h3C, 0, 32'h704);
        idle(32'h3C);
        check("rst_train_predpc", predicted_pc, 32'h40);
        idle(32'hFFFF_FFFC);
        // Random traffic: branches on low addresses, jumps on high addresses
        for (int n = 0; n < 600; n++) begin
            bpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            jpc = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            case ($urandom_range(0, 5))
                0:       op = OP_JAL;
                1:       op = OP_JALR;
                2:       op = 7'h13;
                default: op = OP_BR;
            endcase
            lpc = ($urandom_range(0, 3) == 0) ? jpc : bpc;
            if ($urandom_range(0, 50) == 0) lpc = 32'hFFFF_FFFC;
            cyc($urandom_range(0, 99) < 2, lpc, $urandom_range(0, 4) == 0, $urandom_range(0, 6) != 0,
                $urandom_range(0, 9) == 0, op, (op == OP_BR) ? bpc : jpc, 1'($urandom),
                $urandom & 32'hFFFF_FFFC);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
